// File: rtl/sync_frame_tx.sv
// Framed serial TX: 1011 sync then DATA_W payload bits MSB first; SYNC_FRAME_TX_PARITY_EN appends an even-parity bit.
// First bit on dout the cycle after accept; start is ignored (not queued) while busy; all outputs registered.
module sync_frame_tx #(
    parameter int         DATA_W   = 8,
    parameter logic [3:0] SYNC_PAT = 4'b1011,
    parameter logic       IDLE_LVL = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    output logic              ready,
    output logic              dout,
    output logic              sync_active,
    output logic              busy,
    output logic              done
);
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

`ifdef SYNC_FRAME_TX_PARITY_EN
    typedef enum logic [1:0] {IDLE, SYNC, DATA, PAR} state_t;
    logic par_q, par_nxt;
`else
    typedef enum logic [1:0] {IDLE, SYNC, DATA} state_t;
`endif

    state_t            state, state_nxt;
    logic [1:0]        scnt, scnt_nxt;
    logic [CNT_W-1:0]  dcnt, dcnt_nxt;
    logic [DATA_W-1:0] shreg, shreg_nxt;
    logic              dout_q, dout_nxt;
    logic              sync_q, sync_nxt;
    logic              busy_q, busy_nxt;
    logic              done_q, done_nxt;
    logic [1:0]        sidx;
    logic              fin;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            scnt   <= '0;
            dcnt   <= '0;
            shreg  <= '0;
            dout_q <= IDLE_LVL;
            sync_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
`ifdef SYNC_FRAME_TX_PARITY_EN
            par_q  <= 1'b0;
`endif
        end else begin
            state  <= state_nxt;
            scnt   <= scnt_nxt;
            dcnt   <= dcnt_nxt;
            shreg  <= shreg_nxt;
            dout_q <= dout_nxt;
            sync_q <= sync_nxt;
            busy_q <= busy_nxt;
            done_q <= done_nxt;
`ifdef SYNC_FRAME_TX_PARITY_EN
            par_q  <= par_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        scnt_nxt  = scnt;
        dcnt_nxt  = dcnt;
        shreg_nxt = shreg;
        dout_nxt  = dout_q;
        sync_nxt  = sync_q;
        busy_nxt  = busy_q;
        done_nxt  = 1'b0;
        fin       = 1'b0;
        // Index of the sync bit to present next: bit (3 - (scnt + 1)).
        sidx      = 2'd2 - scnt;
`ifdef SYNC_FRAME_TX_PARITY_EN
        par_nxt   = par_q;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SYNC;
                    shreg_nxt = data_in;
                    scnt_nxt  = 2'd0;
                    dout_nxt  = SYNC_PAT[3];
                    sync_nxt  = 1'b1;
                    busy_nxt  = 1'b1;
`ifdef SYNC_FRAME_TX_PARITY_EN
                    par_nxt   = ^data_in;
`endif
                end
            end
            SYNC: begin
                if (scnt == 2'd3) begin
                    state_nxt = DATA;
                    dcnt_nxt  = '0;
                    dout_nxt  = shreg[DATA_W-1];
                    shreg_nxt = shreg << 1;
                    sync_nxt  = 1'b0;
                end else begin
                    scnt_nxt  = scnt + 2'd1;
                    dout_nxt  = SYNC_PAT[sidx];
                end
            end
            DATA: begin
                if (dcnt == LAST) begin
`ifdef SYNC_FRAME_TX_PARITY_EN
                    state_nxt = PAR;
                    dout_nxt  = par_q;
`else
                    fin       = 1'b1;
`endif
                end else begin
                    dcnt_nxt  = dcnt + CNT_W'(1);
                    dout_nxt  = shreg[DATA_W-1];
                    shreg_nxt = shreg << 1;
                end
            end
`ifdef SYNC_FRAME_TX_PARITY_EN
            PAR: fin = 1'b1;
`endif
            default: state_nxt = IDLE;
        endcase
        // Frame end: line returns to idle level and ready rises alongside the done pulse.
        if (fin) begin
            state_nxt = IDLE;
            dout_nxt  = IDLE_LVL;
            sync_nxt  = 1'b0;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
        end
    end

    assign dout        = dout_q;
    assign sync_active = sync_q;
    assign busy        = busy_q;
    assign ready       = ~busy_q;
    assign done        = done_q;
endmodule
